// File: rtl/matmul_operand_feeder_if.sv
// matmul_operand_feeder_if: control, operand-memory and MAC-side signals of the operand feeder
// master: feeder side (drives addresses, operands, framing, result strobes; receives go and read data)
// slave: environment side (memories, MAC, result writer, controller)
interface matmul_operand_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              go;
  logic              busy;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [5:0]        temp_cnt;
  logic              op_valid;
  logic              start;
  logic              done;
  logic              res_valid;
  logic [5:0]        res_row;
  logic [5:0]        res_col;
  modport master (
    input  go, a_rdata, b_rdata,
    output busy, a_addr, b_addr, a, b, temp_cnt, op_valid, start, done, res_valid, res_row, res_col
  );
  modport slave (
    output go, a_rdata, b_rdata,
    input  busy, a_addr, b_addr, a, b, temp_cnt, op_valid, start, done, res_valid, res_row, res_col
  );
endinterface

// File: rtl/matmul_operand_feeder.sv
// matmul_operand_feeder: streams A/B operand pairs from synchronous-read memories to a MAC with result strobes
// Ports: clk; rst (sync, active high); bus (matmul_operand_feeder_if.master):
//   go/busy control, a_addr/b_addr and a_rdata/b_rdata to the memories,
//   a/b/temp_cnt/op_valid to the MAC, start/done framing, res_valid/res_row/res_col result capture.
// Build option: define TRANSPOSE_B_EN when B is stored transposed (b_addr = j*N+k).
module matmul_operand_feeder #(
  parameter int N       = 8,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int RES_LAT = 2
) (
  input logic                     clk,
  input logic                     rst,
  matmul_operand_feeder_if.master bus
);
  typedef enum logic [2:0] {IDLE, START, ISSUE, DRAIN, FINISH} state_t;
  localparam logic [5:0]        last_idx = 6'(N - 1);
  localparam logic [ADDR_W-1:0] n_a      = ADDR_W'(N);
  state_t              state_q;
  logic [5:0]          i_q, j_q, k_q;
  logic                start_q, done_q, busy_q;
  logic                v1_q;
  logic [5:0]          i1_q, j1_q, k1_q;
  logic                op_valid_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [5:0]          temp_cnt_q, i2_q, j2_q;
  logic [RES_LAT-1:0]  rv_q;
  logic [5:0]          rr_q [RES_LAT];
  logic [5:0]          rc_q [RES_LAT];
  logic                k_last, j_last, i_last, fire, res_last;
  assign k_last   = k_q == last_idx;
  assign j_last   = j_q == last_idx;
  assign i_last   = i_q == last_idx;
  assign fire     = op_valid_q && temp_cnt_q == last_idx;
  // DRAIN ends on the strobe for the bottom-right element, the last one of the run
  assign res_last = rv_q[RES_LAT-1] && rr_q[RES_LAT-1] == last_idx && rc_q[RES_LAT-1] == last_idx;
  assign bus.a_addr = ADDR_W'(i_q) * n_a + ADDR_W'(k_q);
`ifdef TRANSPOSE_B_EN
  assign bus.b_addr = ADDR_W'(j_q) * n_a + ADDR_W'(k_q);
`else
  assign bus.b_addr = ADDR_W'(k_q) * n_a + ADDR_W'(j_q);
`endif
  assign bus.busy      = busy_q;
  assign bus.start     = start_q;
  assign bus.done      = done_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.temp_cnt  = temp_cnt_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.res_valid = rv_q[RES_LAT-1];
  assign bus.res_row   = rr_q[RES_LAT-1];
  assign bus.res_col   = rc_q[RES_LAT-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.go) begin
          state_q <= START;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        START: begin
          state_q <= ISSUE;
          i_q     <= '0;
          j_q     <= '0;
          k_q     <= '0;
        end
        ISSUE: begin
          k_q <= k_last ? '0 : k_q + 6'd1;
          j_q <= !k_last ? j_q : j_last ? '0 : j_q + 6'd1;
          i_q <= !(k_last && j_last) ? i_q : i_last ? '0 : i_q + 6'd1;
          if (k_last && j_last && i_last) state_q <= DRAIN;
        end
        DRAIN: if (res_last) begin
          state_q <= FINISH;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // stage 1 waits for the synchronous memory read; stage 2 registers the operands
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      i1_q       <= '0;
      j1_q       <= '0;
      k1_q       <= '0;
      op_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      temp_cnt_q <= '0;
      i2_q       <= '0;
      j2_q       <= '0;
      rv_q       <= '0;
      for (int n = 0; n < RES_LAT; n++) begin
        rr_q[n] <= '0;
        rc_q[n] <= '0;
      end
    end else begin
      v1_q       <= state_q == ISSUE;
      i1_q       <= i_q;
      j1_q       <= j_q;
      k1_q       <= k_q;
      op_valid_q <= v1_q;
      a_q        <= v1_q ? bus.a_rdata : '0;
      b_q        <= v1_q ? bus.b_rdata : '0;
      temp_cnt_q <= v1_q ? k1_q : '0;
      i2_q       <= i1_q;
      j2_q       <= j1_q;
      rv_q[0]    <= fire;
      rr_q[0]    <= fire ? i2_q : '0;
      rc_q[0]    <= fire ? j2_q : '0;
      for (int n = 1; n < RES_LAT; n++) begin
        rv_q[n] <= rv_q[n-1];
        rr_q[n] <= rr_q[n-1];
        rc_q[n] <= rc_q[n-1];
      end
    end
  end
endmodule

// File: tb/tb_matmul_operand_feeder.sv
// tb_matmul_operand_feeder: directed checks of the operand feeder at N=2 and N=8
module tb_matmul_operand_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  matmul_operand_feeder_if #(.DATA_W(8), .ADDR_W(6)) bus2 ();
  matmul_operand_feeder_if #(.DATA_W(8), .ADDR_W(6)) bus8 ();
  matmul_operand_feeder #(.N(2), .DATA_W(8), .ADDR_W(6), .RES_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(bus2));
  matmul_operand_feeder #(.N(8), .DATA_W(8), .ADDR_W(6), .RES_LAT(2)) u8 (.clk(clk), .rst(rst), .bus(bus8));
  logic [7:0] a2m [64];
  logic [7:0] b2m [64];
  logic [7:0] a8m [64];
  logic [7:0] b8m [64];
  always @(posedge clk) begin
    bus2.a_rdata <= a2m[bus2.a_addr];
    bus2.b_rdata <= b2m[bus2.b_addr];
    bus8.a_rdata <= a8m[bus8.a_addr];
    bus8.b_rdata <= b8m[bus8.b_addr];
  end
  int n_err = 0;
  int n_chk = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask
  int          g0;
  int          st_q[$];
  int          dn_q[$];
  logic [31:0] op_q[$];
  logic [31:0] res_q[$];
  int          c_q[$];
  int          busy_n;
  int          accv;
  task automatic chk_zero(input string pfx);
    chk({pfx, "_ctl"}, {27'd0, bus2.busy, bus2.start, bus2.done, bus2.op_valid, bus2.res_valid}, 32'd0);
    chk({pfx, "_op"}, {2'd0, bus2.temp_cnt, bus2.a, bus2.b, 8'd0}, 32'd0);
    chk({pfx, "_addr"}, {bus2.a_addr, bus2.b_addr, bus2.res_row, bus2.res_col, 8'd0}, 32'd0);
  endtask
  // go is high in relative cycle 0 and again for relative cycles go_from..go_to
  task automatic mon2(input int len, input int go_from, input int go_to);
    st_q.delete(); dn_q.delete(); op_q.delete(); res_q.delete(); c_q.delete();
    busy_n = 0;
    accv = 0;
    g0 = cyc;
    bus2.go = 1'b1;
    for (int r = 1; r <= len; r++) begin
      @(negedge clk);
      bus2.go = r >= go_from && r <= go_to;
      if (bus2.start) st_q.push_back(r);
      if (bus2.done) dn_q.push_back(r);
      if (bus2.busy) busy_n++;
      if (bus2.op_valid) begin
        op_q.push_back({8'(r), bus2.a, bus2.b, 2'b0, bus2.temp_cnt});
        accv = (bus2.temp_cnt == 6'd0 ? 0 : accv) + bus2.a * bus2.b;
        if (bus2.temp_cnt == 6'd1) c_q.push_back(accv);
      end
      if (bus2.res_valid)
        res_q.push_back({8'(r), 2'b0, bus2.res_row, 2'b0, bus2.res_col, 8'(c_q.size() > 0 ? c_q.pop_front() : 255)});
    end
  endtask
  task automatic chk_run2(input string pfx);
    logic [7:0] ea [8] = '{1, 2, 1, 2, 3, 4, 3, 4};
    logic [7:0] eb [8] = '{5, 7, 6, 8, 5, 7, 6, 8};
    logic [7:0] ec [4] = '{19, 22, 43, 50};
    chk({pfx, "_start_n"}, st_q.size(), 1);
    chk({pfx, "_start_cyc"}, st_q.size() > 0 ? st_q[0] : -1, 1);
    chk({pfx, "_op_n"}, op_q.size(), 8);
    for (int p = 0; p < 8; p++)
      chk({pfx, "_op"}, p < op_q.size() ? op_q[p] : 32'hffff_ffff, {8'(4 + p), ea[p], eb[p], 8'(p % 2)});
    chk({pfx, "_res_n"}, res_q.size(), 4);
    for (int p = 0; p < 4; p++)
      chk({pfx, "_res"}, p < res_q.size() ? res_q[p] : 32'hffff_ffff, {8'(7 + 2 * p), 8'(p / 2), 8'(p % 2), ec[p]});
    chk({pfx, "_done_n"}, dn_q.size(), 1);
    chk({pfx, "_done_cyc"}, dn_q.size() > 0 ? dn_q[0] : -1, 14);
    chk({pfx, "_busy_n"}, busy_n, 13);
  endtask
  initial begin
    int n_bad, nres, d8, last8, b8n, acc8;
    int c8[$];
    bus2.go = 1'b0;
    bus8.go = 1'b0;
    for (int n = 0; n < 64; n++) begin
      a2m[n] = 8'd0; b2m[n] = 8'd0; a8m[n] = 8'd0; b8m[n] = 8'd0;
    end
    a2m[0] = 8'd1; a2m[1] = 8'd2; a2m[2] = 8'd3; a2m[3] = 8'd4;
`ifdef TRANSPOSE_B_EN
    b2m[0] = 8'd5; b2m[1] = 8'd7; b2m[2] = 8'd6; b2m[3] = 8'd8;
    for (int j = 0; j < 8; j++) for (int k = 0; k < 8; k++) b8m[j * 8 + k] = 8'(k * 8 + j);
`else
    b2m[0] = 8'd5; b2m[1] = 8'd6; b2m[2] = 8'd7; b2m[3] = 8'd8;
    for (int n = 0; n < 64; n++) b8m[n] = 8'(n);
`endif
    for (int n = 0; n < 8; n++) a8m[n * 9] = 8'd1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon2(16, 99, 0);
    chk_run2("run1");
    repeat (2) @(negedge clk);
    g0 = cyc;
    bus2.go = 1'b1;
    for (int r = 1; r <= 6; r++) begin
      @(negedge clk);
      bus2.go = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    n_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus2.done || bus2.busy || bus2.op_valid || bus2.res_valid) n_bad++;
    end
    chk("midrst_quiet", n_bad, 0);
    mon2(16, 99, 0);
    chk_run2("after_rst");
    repeat (2) @(negedge clk);
    mon2(32, 5, 16);
    chk("held_start_n", st_q.size(), 2);
    chk("held_done_n", dn_q.size(), 2);
    chk("held_start2", st_q.size() > 1 ? st_q[1] : -1, 16);
    chk("held_done1", dn_q.size() > 0 ? dn_q[0] : -1, 14);
    chk("held_done2", dn_q.size() > 1 ? dn_q[1] : -1, 29);
    chk("held_res_n", res_q.size(), 8);
    repeat (2) @(negedge clk);
    nres = 0; d8 = -1; last8 = -1; b8n = 0; acc8 = 0;
    bus8.go = 1'b1;
    for (int r = 1; r <= 530; r++) begin
      @(negedge clk);
      bus8.go = 1'b0;
      if (bus8.busy) b8n++;
      if (bus8.done) d8 = r;
      if (bus8.op_valid) begin
        acc8 = (bus8.temp_cnt == 6'd0 ? 0 : acc8) + bus8.a * bus8.b;
        if (bus8.temp_cnt == 6'd7) c8.push_back(acc8);
      end
      if (bus8.res_valid) begin
        chk("n8_res", {10'd0, bus8.res_row, 2'd0, bus8.res_col, 8'(c8.size() > 0 ? c8.pop_front() : 255)},
            {8'd0, 8'(nres / 8), 8'(nres % 8), 8'(nres)});
        nres++;
        last8 = r;
      end
    end
    chk("n8_res_n", nres, 64);
    chk("n8_last_res", last8, 517);
    chk("n8_done", d8, 518);
    chk("n8_busy_n", b8n, 517);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
